// File: rtl/scrypt_nonce_scan.sv
// Nonce-sweep controller: drives LANES external scrypt cores in batches over an
// inclusive nonce range and reports the lowest nonce whose hash is <= target.
module scrypt_nonce_scan #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned NONCE_OFS  = 0,
  parameter bit          SWAP_NONCE = 1'b1,
  parameter bit          HASH_LE    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [639:0]           header,
  input  logic [255:0]           target,
  input  logic [31:0]            nonce_first,
  input  logic [31:0]            nonce_last,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic                   exhausted,
  output logic [31:0]            found_nonce,
  output logic [255:0]           found_hash,
  output logic [LANES-1:0]       core_enable,
  output logic [LANES*640-1:0]   core_data,
  input  logic [LANES-1:0]       core_done,
  input  logic [LANES*256-1:0]   core_hash
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK} state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned b = 0; b < 4; b++) r[8*b +: 8] = v[8*(3-b) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] r;
    for (int unsigned b = 0; b < 32; b++) r[8*b +: 8] = v[8*(31-b) +: 8];
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [639:0]           header_q, header_d;
  logic [255:0]           target_q, target_d;
  logic [31:0]            base_q, base_d;
  logic [32:0]            remaining_q, remaining_d;
  logic [LANES-1:0]       issue_mask_q, issue_mask_d;
  logic [LANES-1:0]       done_mask_q, done_mask_d;
  logic [LANES-1:0][255:0] hash_q, hash_d;
  logic                   abort_pend_q, abort_pend_d;
  logic [31:0]            found_nonce_q, found_nonce_d;
  logic [255:0]           found_hash_q, found_hash_d;
  logic                   done_q, done_d;
  logic                   found_q, found_d;
  logic                   exhausted_q, exhausted_d;

  logic [LANES-1:0]       lane_mask;
  logic [31:0]            lane_nonce;
  logic [639:0]           lane_hdr;
  logic                   hit;
  logic [31:0]            hit_nonce;
  logic [255:0]           hit_hash;

  // Lane views: core_data stays valid for a lane until its done is absorbed,
  // and the match search walks lanes upward so the lowest nonce wins.
  always_comb begin
    lane_mask   = '0;
    lane_nonce  = '0;
    lane_hdr    = '0;
    core_data   = '0;
    hit         = 1'b0;
    hit_nonce   = '0;
    hit_hash    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_nonce = base_q + 32'(i);
      lane_hdr   = header_q;
      lane_hdr[NONCE_OFS +: 32] = SWAP_NONCE ? bswap32(lane_nonce) : lane_nonce;
      lane_mask[i] = (33'(i) < remaining_q);
      if ((state_q == S_ISSUE && lane_mask[i]) ||
          (state_q == S_WAIT && issue_mask_q[i] && !done_mask_q[i]))
        core_data[640*i +: 640] = lane_hdr;
      if (!hit && issue_mask_q[i] && (hash_q[i] <= target_q)) begin
        hit       = 1'b1;
        hit_nonce = lane_nonce;
        hit_hash  = hash_q[i];
      end
    end
    core_enable = (state_q == S_ISSUE) ? lane_mask : '0;
  end

  always_comb begin
    state_d       = state_q;
    header_d      = header_q;
    target_d      = target_q;
    base_d        = base_q;
    remaining_d   = remaining_q;
    issue_mask_d  = issue_mask_q;
    done_mask_d   = done_mask_q;
    hash_d        = hash_q;
    abort_pend_d  = abort_pend_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    done_d        = 1'b0;
    found_d       = 1'b0;
    exhausted_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          header_d     = header;
          target_d     = target;
          base_d       = nonce_first;
          remaining_d  = {1'b0, nonce_last - nonce_first} + 33'd1;
          abort_pend_d = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_mask_d = lane_mask;
        done_mask_d  = '0;
        if (abort) abort_pend_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        done_mask_d = done_mask_q | (core_done & issue_mask_q);
        for (int unsigned i = 0; i < LANES; i++) begin
          if (core_done[i] && issue_mask_q[i])
            hash_d[i] = HASH_LE ? bswap256(core_hash[256*i +: 256])
                                : core_hash[256*i +: 256];
        end
        if (abort) abort_pend_d = 1'b1;
        if (done_mask_d == issue_mask_q) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (hit) begin
          found_nonce_d = hit_nonce;
          found_hash_d  = hit_hash;
          done_d        = 1'b1;
          found_d       = 1'b1;
          state_d       = S_IDLE;
        end else if (abort_pend_q || abort) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (remaining_q <= 33'(LANES)) begin
          done_d      = 1'b1;
          exhausted_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          base_d      = base_q + 32'(LANES);
          remaining_d = remaining_q - 33'(LANES);
          state_d     = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      header_q      <= '0;
      target_q      <= '0;
      base_q        <= '0;
      remaining_q   <= '0;
      issue_mask_q  <= '0;
      done_mask_q   <= '0;
      hash_q        <= '0;
      abort_pend_q  <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      header_q      <= header_d;
      target_q      <= target_d;
      base_q        <= base_d;
      remaining_q   <= remaining_d;
      issue_mask_q  <= issue_mask_d;
      done_mask_q   <= done_mask_d;
      hash_q        <= hash_d;
      abort_pend_q  <= abort_pend_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      done_q        <= done_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;

endmodule
